alu_regfile: RTL and testbench

ALU_REGFILE -- requirements
Module: alu_regfile

---
 rtl/alu_regfile_pkg.sv | 22 ++
 rtl/alu_regfile_alu_unit.sv | 42 ++++
 rtl/alu_regfile.sv | 63 ++++++
 tb/tb_alu_regfile.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_pkg.sv
// rtl/alu_regfile_pkg.sv - shared typedefs and ALU operation codes for alu_regfile
package alu_regfile_pkg;

  typedef logic        u1;
  typedef logic [1:0]  u2;
  typedef logic [2:0]  u3;
  typedef logic [4:0]  u5;
  typedef logic [31:0] u32;

  // Native word width; the datapath parameter defaults to this.
  localparam int WORD_W = $bits(u32);

  localparam u3 ALU_AND  = 3'b000;
  localparam u3 ALU_OR   = 3'b001;
  localparam u3 ALU_ADD  = 3'b010;
  localparam u3 ALU_ZERO = 3'b011;
  localparam u3 ALU_ANDN = 3'b100;
  localparam u3 ALU_ORN  = 3'b101;
  localparam u3 ALU_SUB  = 3'b110;
  localparam u3 ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_regfile_alu_unit.sv
// rtl/alu_regfile_alu_unit.sv - purely combinational ALU (logic ops, add/sub, signed SLT)
module alu_unit
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  u3                 alucont,
  output logic [DATA_W-1:0] result,
  output u1                 zero
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  u2                 msbs;
  u1                 ovf;
  u1                 slt;

  // Operation select; SLT takes the sign of A-B and flips it when the subtraction overflowed.
  always_comb begin
    sum    = A + B;
    diff   = A - B;
    msbs   = {A[DATA_W-1], B[DATA_W-1]};
    ovf    = (msbs[1] ^ msbs[0]) & (diff[DATA_W-1] ^ msbs[1]);
    slt    = diff[DATA_W-1] ^ ovf;
    result = '0;
    unique case (alucont)
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_ADD:  result = sum;
      ALU_ZERO: result = '0;
      ALU_ANDN: result = A & ~B;
      ALU_ORN:  result = A | ~B;
      ALU_SUB:  result = diff;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, slt};
      default:  result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 32-entry register file (2R/1W) plus ALU; REGFILE_BYPASS_EN enables write-to-read forwarding
module alu_regfile
  import alu_regfile_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  u1                 we3,
  input  u5                 ra1,
  input  u5                 ra2,
  input  u5                 wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  u3                 alucont,
  output logic [DATA_W-1:0] result,
  output u1                 zero
);

  logic [DATA_W-1:0] regs [0:REG_N-1];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  // Register array: cleared asynchronously by reset; register 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (we3 && (wa3 != 5'd0)) begin
      regs[wa3] <= wd3;
    end
  end

  // Zero-latency read ports; address 0 is hardwired to zero.
  always_comb begin
    stored1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    stored2 = (ra2 == 5'd0) ? '0 : regs[ra2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay zero while cleared.
    rd1 = (reset && we3 && (wa3 != 5'd0) && (wa3 == ra1)) ? wd3 : stored1;
    rd2 = (reset && we3 && (wa3 != 5'd0) && (wa3 == ra2)) ? wd3 : stored2;
`else
    rd1 = stored1;
    rd2 = stored2;
`endif
  end

  alu_unit #(
    .DATA_W(DATA_W)
  ) u_alu (
    .A      (A),
    .B      (B),
    .alucont(alucont),
    .result (result),
    .zero   (zero)
  );

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - scoreboard testbench for alu_regfile against a behavioural model
module tb_alu_regfile;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1, ra2, wa3;
  logic [31:0] wd3, rd1, rd2, A, B, result;
  logic [2:0]  alucont;
  logic        zero;

  typedef struct {
    int          id;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:31];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_issued = 0;

  alu_regfile dut (
    .clk    (clk),
    .reset  (reset),
    .we3    (we3),
    .ra1    (ra1),
    .ra2    (ra2),
    .wa3    (wa3),
    .wd3    (wd3),
    .rd1    (rd1),
    .rd2    (rd2),
    .A      (A),
    .B      (B),
    .alucont(alucont),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return 32'd0;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(logic rst, logic we, logic [4:0] wa,
                                           logic [31:0] wd, logic [4:0] ra);
    if (!rst || ra == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return mem[ra];
  endfunction

  // Apply one transaction just after a rising edge and record what the DUT must show this cycle.
  task automatic issue(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; we3 = we; wa3 = wa; wd3 = wd; ra1 = r1; ra2 = r2; A = a; B = b; alucont = op;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end
    e.id  = n_issued;
    e.rd1 = ref_read(rst, we, wa, wd, r1);
    e.rd2 = ref_read(rst, we, wa, wd, r2);
    e.res = ref_alu(a, b, op);
    e.z   = (e.res == 32'd0);
    sb.push_back(e);
    n_issued++;
    if (rst && we && wa != 5'd0) mem[wa] = wd;
  endtask

  task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s txn %0d: got %h required %h", name, id, got, want);
  endtask

  // Monitor: outputs are combinational, so each issued transaction is observed mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rd1", e.id, rd1, e.rd1);
        check("rd2", e.id, rd2, e.rd2);
        check("result", e.id, result, e.res);
        check("zero", e.id, {31'd0, zero}, {31'd0, e.z});
      end
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
    A = '0; B = '0; alucont = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hxxxx_xxxx;

    // Reset pulse, with a write attempt that must be lost.
    issue(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd5, 5'd31, 32'd0, 32'd0, 3'd0);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 32'd0, 32'd0, 3'd0);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 32'd0, 32'd0, 3'd0);
    // Write reg 3, read back; write to reg 0 discarded.
    issue(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'd0, 32'd0, 3'd3);
    issue(1'b1, 1'b1, 5'd0, 32'h0000_1234, 5'd3, 5'd0, 32'd0, 32'd0, 3'd3);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 32'd0, 32'd0, 3'd3);
    // Same-cycle write/read of reg 7, then settled value.
    issue(1'b1, 1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd7, 32'd0, 32'd0, 3'd0);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3, 32'd0, 32'd0, 3'd0);
    // ALU corner cases.
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 3'd2);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd7, 32'd5, 3'd6);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0, 3'd0);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0, 3'd1);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0, 3'd4);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 3'd7);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'h8000_0000, 3'd7);
    issue(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 3'd7);

    // Fill every register so random reads see defined contents.
    for (int r = 1; r < 32; r++) begin
      issue(1'b1, 1'b1, r[4:0], $urandom, 5'($urandom), 5'($urandom), $urandom, $urandom, 3'($urandom));
    end

    // Random traffic with occasional mid-run resets (ALU unaffected by them).
    for (int n = 0; n < 400; n++) begin
      issue(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom), pick_operand(), pick_operand(), 3'($urandom));
    end

    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
